// File: rtl/uart_rx_if.sv
// Receive-side byte handshake and status bundle for uart_rx.
// master = the receiver (producer of bytes), slave = the consuming fabric logic.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling with a fixed
// clocks-per-bit divider, valid/ready byte delivery, framing/overrun pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic      system_clk,
  input  logic      reset_n,
  input  logic      uart0_rxd,
  uart_rx_if.master rx_if
);

  // Derived from CLKS_PER_BIT; kept local so it cannot be overridden.
  localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  logic        sync1_q,     sync1_d;
  logic        rxd_s_q,     rxd_s_d;
  state_e      state_q,     state_d;
  logic [15:0] cnt_q,       cnt_d;
  logic [2:0]  bit_idx_q,   bit_idx_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  rx_data_q,   rx_data_d;
  logic        rx_valid_q,  rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q,   overrun_d;
  logic        busy_q,      busy_d;

  // Next-state logic: synchroniser, bit timing, shifting and byte delivery.
  always_comb begin
    sync1_d     = uart0_rxd;
    rxd_s_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    // A held byte is consumed by the handshake; a delivery below may re-set it.
    rx_valid_d  = rx_valid_q & ~rx_if.rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) state_d = START;
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            // Leave at mid-stop-bit so a back-to-back start edge is not missed.
            state_d = IDLE;
            if (!rx_valid_q || rx_if.rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxd_s_q) state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state and registered outputs; async active-low reset.
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rxd_s_q     <= rxd_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of single frames
// plus hand-written back-to-back, framing, overrun, glitch and reset cases.
module tb_uart_rx;
  localparam int unsigned CPB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;

  uart_rx_if u_if();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .system_clk (clk),
    .reset_n    (rst_n),
    .uart0_rxd  (rxd),
    .rx_if      (u_if)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Event log filled by the monitor
  logic [7:0]  dq[$];
  int unsigned tq[$];
  int nfe  = 0;
  int novr = 0;
  int vhi  = 0;
  logic pv = 1'b0;
  logic pr = 1'b0;

  // Monitor on the falling edge: a byte is new unless it was held unconsumed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.rx_valid && !(pv && !pr)) begin
        dq.push_back(u_if.rx_data);
        tq.push_back(cyc);
      end
      if (u_if.rx_valid)  vhi++;
      if (u_if.frame_err) nfe++;
      if (u_if.overrun)   novr++;
      pv = u_if.rx_valid;
      pr = u_if.rx_ready;
    end else begin
      pv = 1'b0;
      pr = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic clear_log();
    dq.delete();
    tq.delete();
    nfe  = 0;
    novr = 0;
    vhi  = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    cycles(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int unsigned t0);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    t0   = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      cycles(CPB);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         n_del;
    int         n_fe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int unsigned t0, t1;
    logic [9:0] fr;

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1};
    vecs[2] = '{8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'h5A, 1'b1, 1, 0};
    vecs[5] = '{8'h81, 1'b0, 0, 1};
    vecs[6] = '{8'h81, 1'b1, 1, 0};
    vecs[7] = '{8'h3C, 1'b1, 1, 0};

    // Reset state
    u_if.rx_ready = 1'b0;
    cycles(3);
    check("reset rx_data",   int'(u_if.rx_data),   0);
    check("reset rx_valid",  int'(u_if.rx_valid),  0);
    check("reset busy",      int'(u_if.busy),      0);
    check("reset frame_err", int'(u_if.frame_err), 0);
    check("reset overrun",   int'(u_if.overrun),   0);
    rst_n = 1'b1;
    idle(10);

    // Table-driven single frames with rx_ready held high
    u_if.rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clear_log();
      send_frame(vecs[i].data, vecs[i].stop, t0);
      idle(40);
      check($sformatf("vec%0d deliveries", i), dq.size(), vecs[i].n_del);
      if (dq.size() > 0) begin
        check($sformatf("vec%0d rx_data", i), int'(dq[0]), int'(vecs[i].data));
        check_range($sformatf("vec%0d latency", i), int'(tq[0] - t0), 154, 156);
      end
      check($sformatf("vec%0d valid cycles", i), vhi, vecs[i].n_del);
      check($sformatf("vec%0d frame_err", i), nfe, vecs[i].n_fe);
      check($sformatf("vec%0d overrun", i), novr, 0);
      check($sformatf("vec%0d busy idle", i), int'(u_if.busy), 0);
    end

    // Back-to-back 0x00, 0xFF with no idle gap
    clear_log();
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    idle(40);
    check("b2b deliveries", dq.size(), 2);
    if (dq.size() == 2) begin
      check("b2b first",   int'(dq[0]), 8'h00);
      check("b2b second",  int'(dq[1]), 8'hFF);
      check("b2b spacing", int'(tq[1] - tq[0]), 160);
    end

    // Framing error followed by a long low line, then a good byte
    clear_log();
    send_frame(8'h3C, 1'b0, t0);
    cycles(40);
    check("ferr wait busy", int'(u_if.busy), 1);
    check("ferr no valid",  int'(u_if.rx_valid), 0);
    idle(20);
    send_frame(8'h81, 1'b1, t1);
    idle(40);
    check("ferr pulses",     nfe, 1);
    check("ferr overrun",    novr, 0);
    check("ferr deliveries", dq.size(), 1);
    if (dq.size() > 0) check("ferr next byte", int'(dq[0]), 8'h81);

    // Overrun: consumer stalled across two bytes
    u_if.rx_ready = 1'b0;
    clear_log();
    send_frame(8'h11, 1'b1, t0);
    idle(20);
    send_frame(8'h22, 1'b1, t1);
    idle(40);
    check("ovr rx_valid",    int'(u_if.rx_valid), 1);
    check("ovr rx_data",     int'(u_if.rx_data), 8'h11);
    check("ovr pulses",      novr, 1);
    check("ovr deliveries",  dq.size(), 1);
    check("ovr frame_err",   nfe, 0);
    u_if.rx_ready = 1'b1;
    cycles(1);
    check("ovr consumed", int'(u_if.rx_valid), 0);

    // 3-cycle low glitch on an idle line
    clear_log();
    rxd = 1'b0;
    cycles(3);
    rxd = 1'b1;
    cycles(2);
    check("glitch busy high", int'(u_if.busy), 1);
    cycles(15);
    check("glitch busy low",   int'(u_if.busy), 0);
    check("glitch deliveries", dq.size(), 0);
    check("glitch frame_err",  nfe, 0);
    check("glitch overrun",    novr, 0);

    // Reset during bit 4 of 0x5A, then 0xC3
    clear_log();
    fr = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd = fr[i];
      cycles(CPB);
    end
    rxd = fr[5];
    cycles(CPB / 2);
    rst_n = 1'b0;
    cycles(3);
    check("rst rx_data",   int'(u_if.rx_data),   0);
    check("rst rx_valid",  int'(u_if.rx_valid),  0);
    check("rst busy",      int'(u_if.busy),      0);
    check("rst frame_err", int'(u_if.frame_err), 0);
    check("rst overrun",   int'(u_if.overrun),   0);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'hC3, 1'b1, t0);
    idle(40);
    check("rst deliveries", dq.size(), 1);
    if (dq.size() > 0) check("rst next byte", int'(dq[0]), 8'hC3);
    check("rst frame_err after", nfe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
